// File: rtl/restoring_divider_ctrl.sv
// Restoring-division controller driving an external subtractor, one trial subtract per cycle.
// Optional macro DIV_EARLY_EXIT_EN: finish at acceptance when dividend < divisor.
module restoring_divider_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    output logic             sub_cin,
    input  logic [WIDTH-1:0] sub_s,
    input  logic             sub_bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        r_d         = r_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        sub_a       = '0;
        sub_b       = '0;
        trial       = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        q_step      = '0;
        r_step      = '0;

        case (state_q)
            ITER: begin
                sub_a = trial;
                sub_b = d_q;
                // A borrow means the trial subtract failed, so the shifted remainder is kept.
                if (!sub_bout) begin
                    r_step = sub_s;
                    q_step = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_step = trial;
                    q_step = {q_q[WIDTH-2:0], 1'b0};
                end
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    quotient_d  = q_step;
                    remainder_d = r_step;
                    cnt_d       = '0;
                    state_d     = DONE;
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
`ifdef DIV_EARLY_EXIT_EN
                    end else if (dividend < divisor) begin
                        quotient_d  = '0;
                        remainder_d = dividend;
                        dbz_d       = 1'b0;
                        state_d     = DONE;
`endif
                    end else begin
                        q_d     = dividend;
                        r_d     = '0;
                        d_d     = divisor;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = ITER;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q == ITER);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign sub_cin     = 1'b0;

endmodule

// File: tb/tb_restoring_divider_ctrl.sv
// Randomized and directed bench for restoring_divider_ctrl against a cycle-level arithmetic model.
module tb_restoring_divider_ctrl;

    localparam int WIDTH = 4;
`ifdef DIV_EARLY_EXIT_EN
    localparam int SMALL_LAT = 1;
`else
    localparam int SMALL_LAT = WIDTH + 1;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic [WIDTH-1:0] sub_a;
    logic [WIDTH-1:0] sub_b;
    logic             sub_cin;
    logic [WIDTH-1:0] sub_s;
    logic             sub_bout;

    int total = 0;
    int bad   = 0;

    restoring_divider_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .sub_a       (sub_a),
        .sub_b       (sub_b),
        .sub_cin     (sub_cin),
        .sub_s       (sub_s),
        .sub_bout    (sub_bout)
    );

    // Behavioural subtractor sitting beside the controller.
    logic [WIDTH:0] diff_wide;
    assign diff_wide = {1'b0, sub_a} - {1'b0, sub_b} - {{WIDTH{1'b0}}, sub_cin};
    assign sub_s     = diff_wide[WIDTH-1:0];
    assign sub_bout  = diff_wide[WIDTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: tracks how many cycles remain and what the results must be using / and %.
    logic             m_busy, m_done, m_dbz;
    logic [WIDTH-1:0] m_q, m_r, m_pq, m_pr;
    int               m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
            m_q = '0; m_r = '0; m_pq = '0; m_pr = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_q    = m_pq;
                    m_r    = m_pr;
                end
            end else if (start) begin
                if (divisor == 0) begin
                    m_done = 1'b1;
                    m_q    = '1;
                    m_r    = dividend;
                    m_dbz  = 1'b1;
                end else if (SMALL_LAT == 1 && dividend < divisor) begin
                    m_done = 1'b1;
                    m_q    = '0;
                    m_r    = dividend;
                    m_dbz  = 1'b0;
                end else begin
                    m_busy = 1'b1;
                    m_left = WIDTH;
                    m_pq   = dividend / divisor;
                    m_pr   = dividend % divisor;
                    m_dbz  = 1'b0;
                end
            end
        end
    end

    // Every cycle, compare all outputs with the model on the falling edge.
    always @(negedge clk) begin
        total = total + 1;
        if ({busy, done, div_by_zero, quotient, remainder, sub_cin} !==
            {m_busy, m_done, m_dbz, m_q, m_r, 1'b0}) begin
            bad = bad + 1;
            $display("[TB] FAIL model t=%0t busy/done/dbz/q/r/cin got %b/%b/%b/%h/%h/%b want %b/%b/%b/%h/%h/0",
                     $time, busy, done, div_by_zero, quotient, remainder, sub_cin,
                     m_busy, m_done, m_dbz, m_q, m_r);
        end
        if (!m_busy) begin
            total = total + 1;
            if ({sub_a, sub_b} !== '0) begin
                bad = bad + 1;
                $display("[TB] FAIL subIdle t=%0t got a=%h b=%h want 0/0", $time, sub_a, sub_b);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Caller sits on a falling edge; lat counts falling edges after E0 until done is seen.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output int lat, output logic busyAt1, output int busyCnt);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
        busyAt1  = busy;
        lat      = 1;
        busyCnt  = 0;
        while (!done && lat < 30) begin
            if (busy) busyCnt = busyCnt + 1;
            @(negedge clk);
            lat = lat + 1;
        end
        if (!done) begin
            total = total + 1;
            bad   = bad + 1;
            $display("[TB] FAIL doneTimeout got no done want done within 30 cycles");
        end
    endtask

    int   lat, busyCnt;
    logic busyAt1;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstQ", quotient, 0);
        checkOutput("rstR", remainder, 0);
        checkOutput("rstDbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        applyStimulus(4'd9, 4'd2, lat, busyAt1, busyCnt);
        checkOutput("lat9by2", lat, WIDTH + 1);
        checkOutput("busyCnt9by2", busyCnt, 4);
        checkOutput("q9by2", quotient, 4'b0100);
        checkOutput("r9by2", remainder, 4'b0001);
        checkOutput("dbz9by2", div_by_zero, 0);

        @(negedge clk);
        applyStimulus(4'd15, 4'd1, lat, busyAt1, busyCnt);
        checkOutput("q15by1", quotient, 4'b1111);
        checkOutput("r15by1", remainder, 4'b0000);
        applyStimulus(4'd15, 4'd15, lat, busyAt1, busyCnt);
        checkOutput("b2bBusy", busyAt1, 1);
        checkOutput("lat15by15", lat, WIDTH + 1);
        checkOutput("q15by15", quotient, 4'b0001);
        checkOutput("r15by15", remainder, 4'b0000);

        @(negedge clk);
        applyStimulus(4'd8, 4'd9, lat, busyAt1, busyCnt);
        checkOutput("lat8by9", lat, SMALL_LAT);
        checkOutput("q8by9", quotient, 4'b0000);
        checkOutput("r8by9", remainder, 4'b1000);

        @(negedge clk);
        applyStimulus(4'd10, 4'd0, lat, busyAt1, busyCnt);
        checkOutput("lat10by0", lat, 1);
        checkOutput("q10by0", quotient, 4'b1111);
        checkOutput("r10by0", remainder, 4'b1010);
        checkOutput("dbz10by0", div_by_zero, 1);
        @(negedge clk);
        applyStimulus(4'd6, 4'd3, lat, busyAt1, busyCnt);
        checkOutput("dbz6by3", div_by_zero, 0);
        checkOutput("q6by3", quotient, 4'b0010);
        checkOutput("r6by3", remainder, 4'b0000);

        // A second start mid-operation must be dropped.
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 4'd1; divisor = 4'd1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat = lat + 1;
        end
        checkOutput("lat13by4", lat, WIDTH + 1);
        checkOutput("q13by4", quotient, 4'b0011);
        checkOutput("r13by4", remainder, 4'b0001);

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDone", done, 0);
        checkOutput("midRstQ", quotient, 0);
        checkOutput("midRstR", remainder, 0);
        checkOutput("midRstDbz", div_by_zero, 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("midRstNoDone", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(4'd14, 4'd3, lat, busyAt1, busyCnt);
        checkOutput("q14by3", quotient, 4'b0100);
        checkOutput("r14by3", remainder, 4'b0010);

        // Random traffic, including starts during busy and back-to-back requests.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 2) == 0);
            dividend = WIDTH'($urandom_range(0, 15));
            divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : WIDTH'($urandom_range(1, 15));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
